// File: rtl/demux_scheduler.sv
// Round-robin sequencer for a 1-to-4 demux: bursts of BURST words per channel,
// per-channel enable mask, optional skip of a stalled channel at burst boundaries.
module demux_scheduler #(
    parameter int unsigned W     = 8,
    parameter int unsigned BURST = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [W-1:0]                   in_data,
    input  logic [3:0]                     chan_en,
    input  logic                           skip_en,
    output logic [3:0]                     out_valid,
    input  logic [3:0]                     out_ready,
    output logic [4*W-1:0]                 out_data,
    output logic [1:0]                     cur_ch,
    output logic [$clog2(BURST+1)-1:0]     burst_cnt
);

    localparam int unsigned BW = $clog2(BURST + 1);
    localparam logic [BW-1:0] LAST = BW'(BURST - 1);

    logic [1:0]    r_cur;
    logic [BW-1:0] r_burst;
    logic [3:0]    r_valid;
    logic [W-1:0]  r_data [4];

    logic [1:0]    w_next_en;
    logic [3:0]    w_free;
    logic          w_cur_en;
    logic          w_accept;
    logic          w_realign;
    logic          w_skip;

    // First enabled channel after p in rotation order; p itself is the last candidate.
    function automatic logic [1:0] next_en(input logic [1:0] p, input logic [3:0] en);
        logic [1:0] cand;
        next_en = p;
        for (int i = 3; i >= 1; i--) begin
            cand = p + 2'(i);
            if (en[cand]) next_en = cand;
        end
    endfunction

    always_comb begin
        w_next_en = next_en(r_cur, chan_en);
        w_free    = ~r_valid | out_ready;
        w_cur_en  = chan_en[r_cur];
        in_ready  = w_cur_en && w_free[r_cur];
        w_accept  = in_valid && in_ready;
        w_realign = !w_cur_en;
        w_skip    = skip_en && (r_burst == '0) && w_cur_en && !w_free[r_cur];
    end

    // Rotation pointer and burst counter; realign outranks accept, which outranks skip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur   <= 2'd0;
            r_burst <= '0;
        end else if (w_realign) begin
            r_cur   <= w_next_en;
            r_burst <= '0;
        end else if (w_accept) begin
            if (r_burst == LAST) begin
                r_burst <= '0;
                r_cur   <= w_next_en;
            end else begin
                r_burst <= r_burst + BW'(1);
            end
        end else if (w_skip) begin
            r_cur <= w_next_en;
        end
    end

    // One-entry output slot per channel; a load wins over a same-cycle drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 4'd0;
            for (int k = 0; k < 4; k++) r_data[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_accept && (r_cur == 2'(k))) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= in_data;
                end else if (r_valid[k] && out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) out_data[k*W +: W] = r_data[k];
    end

    assign out_valid = r_valid;
    assign cur_ch    = r_cur;
    assign burst_cnt = r_burst;

endmodule

// File: tb/tb_demux_scheduler.sv
// Directed bench for demux_scheduler (W=8, BURST=2) with hand-computed expectations.
module tb_demux_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [3:0]  chan_en;
    logic        skip_en;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [1:0]  cur_ch;
    logic [1:0]  burst_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    demux_scheduler #(.W(8), .BURST(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .chan_en   (chan_en),
        .skip_en   (skip_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cur_ch    (cur_ch),
        .burst_cnt (burst_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] slot(input int ch);
        logic [31:0] d;
        d = out_data;
        return d[ch*8 +: 8];
    endfunction

    // Present one word, require it to be accepted, then check it landed in channel ch.
    task automatic send(input int ch, input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        check("in_ready_send", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("slot_valid", 32'(out_valid[ch]), 32'd1);
        check("slot_data", 32'(slot(ch)), 32'(d));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        chan_en = 4'hF; skip_en = 1'b0; out_ready = 4'hF;
        #2;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_cur", 32'(cur_ch), 32'd0);
        check("reset_burst", 32'(burst_cnt), 32'd0);
        check("reset_data", out_data, 32'd0);
        tick();
        rst = 1'b0;

        // 1: full rotation, two words per channel, back to back
        for (int i = 0; i < 8; i++) send(i / 2, 8'(8'h10 + i));
        check("t1_cur", 32'(cur_ch), 32'd0);
        check("t1_burst", 32'(burst_cnt), 32'd0);

        // 2: channels 1 and 3 only, realign from reset
        do_reset();
        chan_en = 4'b1010;
        in_valid = 1'b1; in_data = 8'hA0;
        #1;
        check("t2_realign_rdy", 32'(in_ready), 32'd0);
        tick();
        check("t2_realign_cur", 32'(cur_ch), 32'd1);
        check("t2_realign_burst", 32'(burst_cnt), 32'd0);
        send(1, 8'hA0);
        send(1, 8'hA1);
        check("t2_mid_cur", 32'(cur_ch), 32'd3);
        send(3, 8'hA2);
        send(3, 8'hA3);
        check("t2_end_cur", 32'(cur_ch), 32'd1);

        // 3: skip-on-stall; park pointer at ch0 with ch0 full and burst_cnt 0
        do_reset();
        chan_en = 4'hF; out_ready = 4'b1110;
        send(0, 8'h33);
        chan_en = 4'b1110;
        tick();
        chan_en = 4'b0001;
        tick();
        check("t3_park_cur", 32'(cur_ch), 32'd0);
        check("t3_park_burst", 32'(burst_cnt), 32'd0);
        chan_en = 4'hF; skip_en = 1'b1;
        #1;
        check("t3_skip_rdy", 32'(in_ready), 32'd0);
        tick();
        check("t3_skip_cur", 32'(cur_ch), 32'd1);
        send(1, 8'h55);
        check("t3_ch0_valid", 32'(out_valid[0]), 32'd1);
        check("t3_ch0_data", 32'(slot(0)), 32'h33);
        skip_en = 1'b0; chan_en = 4'b0001;
        tick();
        chan_en = 4'hF;
        in_valid = 1'b1; in_data = 8'h66;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_noskip_rdy", 32'(in_ready), 32'd0);
            tick();
            check("t3_noskip_cur", 32'(cur_ch), 32'd0);
        end
        in_valid = 1'b0;
        check("t3_ch0_kept", 32'(slot(0)), 32'h33);

        // 4: disable channel 2 mid-burst
        do_reset();
        chan_en = 4'hF; out_ready = 4'b1011;
        send(0, 8'h01); send(0, 8'h02); send(1, 8'h03); send(1, 8'h04);
        send(2, 8'h40);
        check("t4_pre_cur", 32'(cur_ch), 32'd2);
        check("t4_pre_burst", 32'(burst_cnt), 32'd1);
        chan_en = 4'b1011;
        in_valid = 1'b1; in_data = 8'h41;
        #1;
        check("t4_rdy", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        check("t4_cur", 32'(cur_ch), 32'd3);
        check("t4_burst", 32'(burst_cnt), 32'd0);
        check("t4_v2_held", 32'(out_valid[2]), 32'd1);
        tick();
        check("t4_v2_still", 32'(out_valid[2]), 32'd1);
        out_ready = 4'hF;
        tick();
        check("t4_v2_drained", 32'(out_valid[2]), 32'd0);

        // 5: no channel enabled
        do_reset();
        chan_en = 4'h0;
        in_valid = 1'b1; in_data = 8'h99;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("t5_rdy", 32'(in_ready), 32'd0);
            tick();
            check("t5_cur", 32'(cur_ch), 32'd0);
            check("t5_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;

        // 6: asynchronous reset mid-burst
        do_reset();
        chan_en = 4'hF; out_ready = 4'b1011;
        send(0, 8'h00); send(0, 8'h01); send(1, 8'h02); send(1, 8'h03);
        out_ready = 4'b1001;
        send(2, 8'h04);
        #1;
        check("t6_pre_valid", 32'(out_valid), 32'b0110);
        rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(out_valid), 32'd0);
        check("t6_async_cur", 32'(cur_ch), 32'd0);
        check("t6_async_burst", 32'(burst_cnt), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 4'hF;
        send(0, 8'h77);
        check("t6_post_cur", 32'(cur_ch), 32'd0);
        check("t6_post_burst", 32'(burst_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
